axi_8bit_adder_join: RTL and testbench

- Downstream consumer of two 8-bit AXI-Stream transmitters in the adder datapath.
- Buffers each operand stream independently and joins one word from each into a single sum.
- Emits the 9-bit sum on a registered AXI-Stream master port.
- Decouples the two random-latency sources from the sink, sustaining 1 sum/cycle when all sides are ready.

---
 rtl/axi_8bit_adder_join.sv | 91 +++++++++
 tb/tb_axi_8bit_adder_join.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_8bit_adder_join.sv
// Joins two buffered 8-bit AXI-Stream operand channels into one registered 9-bit sum stream.
// Optional macro ADDER_SATURATE_EN: saturate sum[7:0] at 255 and use bit 8 as the overflow flag.
module axi_8bit_adder_join #(
  parameter int DEPTH = 2,
  parameter int OUT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_a_valid,
  output logic             s_axis_a_ready,
  input  logic [7:0]       s_axis_a_data,
  input  logic             s_axis_b_valid,
  output logic             s_axis_b_ready,
  input  logic [7:0]       s_axis_b_data,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic [OUT_W-1:0] m_axis_data
);
  localparam int          AW     = (DEPTH > 2) ? 2 : 1;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  // A beat transfers on a rising edge where valid and ready are both high; a source
  // holds valid/data until then, and readies come only from local buffer occupancy.
  logic [7:0]       r_a_mem [DEPTH];
  logic [7:0]       r_b_mem [DEPTH];
  logic [AW-1:0]    r_a_wr, r_a_rd, r_b_wr, r_b_rd;
  logic [AW:0]      r_a_cnt, r_b_cnt;
  logic             r_valid;
  logic [OUT_W-1:0] r_data;

  logic             w_a_push, w_b_push, w_fire;
  logic [OUT_W-1:0] w_sum, w_result;

  assign s_axis_a_ready = (r_a_cnt != L_FULL);
  assign s_axis_b_ready = (r_b_cnt != L_FULL);
  assign w_a_push       = s_axis_a_valid & s_axis_a_ready;
  assign w_b_push       = s_axis_b_valid & s_axis_b_ready;
  assign w_fire         = (r_a_cnt != '0) & (r_b_cnt != '0) & (~r_valid | m_axis_ready);
  assign w_sum          = {1'b0, r_a_mem[r_a_rd]} + {1'b0, r_b_mem[r_b_rd]};

`ifdef ADDER_SATURATE_EN
  assign w_result = w_sum[8] ? {1'b1, 8'hFF} : w_sum;
`else
  assign w_result = w_sum;
`endif

  assign m_axis_valid = r_valid;
  assign m_axis_data  = r_data;

  // Storage needs no reset: occupancy counts alone decide what is readable.
  always_ff @(posedge clk) begin
    if (w_a_push) r_a_mem[r_a_wr] <= s_axis_a_data;
    if (w_b_push) r_b_mem[r_b_wr] <= s_axis_b_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_wr  <= '0;
      r_a_rd  <= '0;
      r_a_cnt <= '0;
      r_b_wr  <= '0;
      r_b_rd  <= '0;
      r_b_cnt <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_a_push) r_a_wr <= r_a_wr + 1'b1;
      if (w_b_push) r_b_wr <= r_b_wr + 1'b1;
      if (w_fire) begin
        r_a_rd <= r_a_rd + 1'b1;
        r_b_rd <= r_b_rd + 1'b1;
      end
      case ({w_a_push, w_fire})
        2'b10:   r_a_cnt <= r_a_cnt + 1'b1;
        2'b01:   r_a_cnt <= r_a_cnt - 1'b1;
        default: r_a_cnt <= r_a_cnt;
      endcase
      case ({w_b_push, w_fire})
        2'b10:   r_b_cnt <= r_b_cnt + 1'b1;
        2'b01:   r_b_cnt <= r_b_cnt - 1'b1;
        default: r_b_cnt <= r_b_cnt;
      endcase
      if (w_fire) begin
        r_valid <= 1'b1;
        r_data  <= w_result;
      end else if (r_valid && m_axis_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_8bit_adder_join.sv
// Randomized bench for axi_8bit_adder_join against a queue-based pairing model.
module tb_axi_8bit_adder_join;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_axis_a_valid = 1'b0, s_axis_b_valid = 1'b0;
  logic [7:0] s_axis_a_data = '0, s_axis_b_data = '0;
  logic       s_axis_a_ready, s_axis_b_ready;
  logic       m_axis_valid;
  logic       m_axis_ready = 1'b0;
  logic [8:0] m_axis_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         acc_a = 0, acc_b = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [8:0] prev_d = '0;
  logic       done_a, done_b;

  axi_8bit_adder_join #(.DEPTH(DEPTH), .OUT_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_a_valid(s_axis_a_valid), .s_axis_a_ready(s_axis_a_ready), .s_axis_a_data(s_axis_a_data),
    .s_axis_b_valid(s_axis_b_valid), .s_axis_b_ready(s_axis_b_ready), .s_axis_b_data(s_axis_b_data),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef ADDER_SATURATE_EN
    return (s > 255) ? 9'h1FF : 9'(s);
`else
    return 9'(s);
`endif
  endfunction

  // Monitor: handshakes seen at the falling edge are the ones the next rising edge takes.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(m_axis_valid), 32'd1);
        check("hold_data", 32'(m_axis_data), 32'(prev_d));
      end
      if (m_axis_valid && m_axis_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(m_axis_data), 32'hFFFF_FFFF);
        else check("beat", 32'(m_axis_data), 32'(exp_q.pop_front()));
        got_q.push_back(m_axis_data);
      end
      if (s_axis_a_valid && s_axis_a_ready) begin qa.push_back(s_axis_a_data); acc_a++; end
      if (s_axis_b_valid && s_axis_b_ready) begin qb.push_back(s_axis_b_data); acc_b++; end
      while (qa.size() != 0 && qb.size() != 0)
        exp_q.push_back(model_sum(qa.pop_front(), qb.pop_front()));
      prev_v = m_axis_valid;
      prev_r = m_axis_ready;
      prev_d = m_axis_data;
    end
  end

  // Drivers start and end at 1 time unit after a rising edge.
  task automatic send_a(input logic [7:0] d);
    logic rdy;
    int   n;
    s_axis_a_valid = 1'b1;
    s_axis_a_data  = d;
    n = 0;
    do begin
      @(negedge clk); rdy = s_axis_a_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 1000);
    if (!rdy) check("send_a_timeout", 32'(rdy), 32'd1);
    s_axis_a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    logic rdy;
    int   n;
    s_axis_b_valid = 1'b1;
    s_axis_b_data  = d;
    n = 0;
    do begin
      @(negedge clk); rdy = s_axis_b_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 1000);
    if (!rdy) check("send_b_timeout", 32'(rdy), 32'd1);
    s_axis_b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_valid) && n < 500) begin
      @(posedge clk); #2; n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base_a, base_b, nb;
    // Reset state
    #1;
    check("rst_valid", 32'(m_axis_valid), 32'd0);
    check("rst_data", 32'(m_axis_data), 32'd0);
    check("rst_a_ready", 32'(s_axis_a_ready), 32'd1);
    check("rst_b_ready", 32'(s_axis_b_ready), 32'd1);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // 1: single pair, latency and one beat
    m_axis_ready = 1'b1;
    s_axis_a_valid = 1'b1; s_axis_a_data = 8'd3;
    s_axis_b_valid = 1'b1; s_axis_b_data = 8'd5;
    @(posedge clk); #1;
    s_axis_a_valid = 1'b0; s_axis_b_valid = 1'b0;
    @(negedge clk); check("t1_valid_k", 32'(m_axis_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_k1", 32'(m_axis_valid), 32'd1);
    check("t1_data", 32'(m_axis_data), 32'h008);
    @(posedge clk);
    @(negedge clk); check("t1_one_beat", 32'(m_axis_valid), 32'd0);
    @(posedge clk); #1;

    // 2: full-rate A, bursty B
    nb = got_q.size();
    fork
      begin send_a(8'd10); send_a(8'd20); send_a(8'd30); end
      begin
        for (int i = 1; i <= 3; i++) begin idle($urandom_range(0, 5)); send_b(8'(i)); end
      end
    join
    drain();
    check("t2_count", 32'(got_q.size() - nb), 32'd3);
    if (got_q.size() >= nb + 3) begin
      check("t2_b0", 32'(got_q[nb]), 32'h00B);
      check("t2_b1", 32'(got_q[nb+1]), 32'h016);
      check("t2_b2", 32'(got_q[nb+2]), 32'h021);
    end

    // 3: output stall fills both buffers
    @(posedge clk); #1;
    m_axis_ready = 1'b0;
    base_a = acc_a; base_b = acc_b;
    fork
      begin for (int i = 0; i < 5; i++) send_a(8'(50 + i)); end
      begin for (int i = 0; i < 5; i++) send_b(8'(i)); end
      begin
        repeat (10) @(posedge clk);
        #1;
        check("t3_acc_a", 32'(acc_a - base_a), 32'(DEPTH + 1));
        check("t3_acc_b", 32'(acc_b - base_b), 32'(DEPTH + 1));
        check("t3_a_ready", 32'(s_axis_a_ready), 32'd0);
        check("t3_b_ready", 32'(s_axis_b_ready), 32'd0);
        check("t3_valid", 32'(m_axis_valid), 32'd1);
        m_axis_ready = 1'b1;
        @(posedge clk); #2;
        check("t3_rel_a_ready", 32'(s_axis_a_ready), 32'd1);
        check("t3_rel_b_ready", 32'(s_axis_b_ready), 32'd1);
        check("t3_rel_valid", 32'(m_axis_valid), 32'd1);
      end
    join
    drain();

    // 4: extreme operands
    @(posedge clk); #1;
    fork send_a(8'd255); send_b(8'd255); join
    drain();
    check("t4_max", 32'(got_q[$]), 32'h1FE);
    fork send_a(8'd200); send_b(8'd100); join
    drain();
`ifdef ADDER_SATURATE_EN
    check("t4_ovf", 32'(got_q[$]), 32'h1FF);
`else
    check("t4_ovf", 32'(got_q[$]), 32'h12C);
`endif
    fork send_a(8'd0); send_b(8'd0); join
    drain();
    check("t4_zero", 32'(got_q[$]), 32'h000);

    // 5: A full with B empty, then B arrives
    @(posedge clk); #1;
    send_a(8'd40); send_a(8'd41);
    idle(3); #1;
    check("t5_a_ready", 32'(s_axis_a_ready), 32'd0);
    check("t5_valid", 32'(m_axis_valid), 32'd0);
    @(posedge clk); #1;
    nb = got_q.size();
    send_b(8'd7);
    drain();
    check("t5_count", 32'(got_q.size() - nb), 32'd1);
    check("t5_sum", 32'(got_q[$]), 32'h02F);

    // 6: reset with a pending sum and buffered operands
    @(posedge clk); #1;
    m_axis_ready = 1'b0;
    send_b(8'd8);
    send_a(8'd1); send_a(8'd2);
    idle(2); #1;
    check("t6_pending", 32'(m_axis_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_axis_valid), 32'd0);
    check("t6_rst_data", 32'(m_axis_data), 32'd0);
    check("t6_rst_a_ready", 32'(s_axis_a_ready), 32'd1);
    check("t6_rst_b_ready", 32'(s_axis_b_ready), 32'd1);
    idle(2);
    rst_n = 1'b1;
    m_axis_ready = 1'b1;
    idle(1);
    nb = got_q.size();
    fork send_a(8'd9); send_b(8'd6); join
    drain();
    check("t6_count", 32'(got_q.size() - nb), 32'd1);
    check("t6_sum", 32'(got_q[$]), 32'h00F);

    // 7: random traffic with random sink backpressure
    @(posedge clk); #1;
    done_a = 1'b0; done_b = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          idle($urandom_range(0, 2)); send_a(8'($urandom_range(0, 255)));
        end
        done_a = 1'b1;
      end
      begin
        for (int i = 0; i < 150; i++) begin
          idle($urandom_range(0, 3)); send_b(8'($urandom_range(0, 255)));
        end
        done_b = 1'b1;
      end
      begin
        while (!(done_a && done_b)) begin
          @(posedge clk); #1;
          m_axis_ready = ($urandom_range(0, 3) != 0);
        end
        m_axis_ready = 1'b1;
      end
    join
    drain();
    check("t7_a_left", 32'(qa.size()), 32'd0);
    check("t7_b_left", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
